// File: rtl/cmd_pad_serdes.sv
// SD CMD pad serializer/deserializer: shifts out 48-bit commands with CRC7,
// captures 48/136-bit responses and reports CRC, end-bit and timeout status.
module cmd_pad_serdes #(
    parameter int unsigned NCR_MAX   = 64,
    parameter int unsigned SHORT_LEN = 48,
    parameter int unsigned LONG_LEN  = 136
) (
    input  logic                sd_clock,
    input  logic                reset,
    input  logic                reset_wrapper,
    input  logic                enable_pts,
    input  logic                enable_stp,
    input  logic                pad_state,
    input  logic                pad_enable,
    input  logic                long_resp,
    input  logic [39:0]         cmd_to_send,
    input  logic                cmd_in,
    output logic                cmd_out,
    output logic                cmd_oe,
    output logic                transmission_complete,
    output logic                reception_complete,
    output logic [LONG_LEN-1:0] pad_response,
    output logic                crc_error,
    output logic                timeout
);

    localparam logic [7:0] LP_NCR     = 8'(NCR_MAX);
    localparam logic [7:0] LP_SHORT   = 8'(SHORT_LEN);
    localparam logic [7:0] LP_LONG    = 8'(LONG_LEN);
    localparam logic [7:0] LP_TX_LEN  = 8'd48;
    localparam logic [7:0] LP_TX_CRC  = 8'd40;

    typedef enum logic [2:0] {IDLE, TX_SHIFT, TX_DONE, RX_WAIT, RX_SHIFT, RX_DONE} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t              r_state, w_state;
    logic [47:0]         r_tx_sr, w_tx_sr;
    logic [LONG_LEN-1:0] r_rx_sr, w_rx_sr, w_rx_shifted;
    logic [7:0]          r_bit_cnt, w_bit_cnt;
    logic [7:0]          r_wait_cnt, w_wait_cnt;
    logic [6:0]          r_crc, w_crc;
    logic                r_long, w_long;
    logic                r_cmd_out, w_cmd_out;
    logic                r_cmd_oe, w_cmd_oe;
    logic                r_tx_done, w_tx_done;
    logic                r_rx_done, w_rx_done;
    logic [LONG_LEN-1:0] r_resp, w_resp;
    logic                r_crc_err, w_crc_err;
    logic                r_timeout, w_timeout;
    logic [7:0]          w_len;
    logic                w_crc_en;

    // r_bit_cnt counts bits already driven (TX) or captured (RX).
    always_comb begin
        w_state      = r_state;
        w_tx_sr      = r_tx_sr;
        w_rx_sr      = r_rx_sr;
        w_bit_cnt    = r_bit_cnt;
        w_wait_cnt   = r_wait_cnt;
        w_crc        = r_crc;
        w_long       = r_long;
        w_cmd_out    = 1'b1;
        w_cmd_oe     = 1'b0;
        w_tx_done    = r_tx_done;
        w_rx_done    = r_rx_done;
        w_resp       = r_resp;
        w_crc_err    = r_crc_err;
        w_timeout    = r_timeout;
        w_rx_shifted = {r_rx_sr[LONG_LEN-2:0], cmd_in};
        w_len        = r_long ? LP_LONG : LP_SHORT;
        // R2 CRC covers only bits 127..8; the leading byte is excluded
        w_crc_en     = r_long ? (r_bit_cnt >= LP_LONG - 8'd128 && r_bit_cnt < LP_LONG - 8'd8)
                              : (r_bit_cnt < LP_SHORT - 8'd8);

        case (r_state)
            IDLE: begin
                if (enable_pts) begin
                    w_tx_sr   = {cmd_to_send, 8'h01};
                    w_cmd_out = cmd_to_send[39];
                    w_cmd_oe  = pad_state & pad_enable;
                    w_crc     = crc7_step(7'd0, cmd_to_send[39]);
                    w_bit_cnt = 8'd1;
                    w_state   = TX_SHIFT;
                end else if (enable_stp) begin
                    w_long     = long_resp;
                    w_wait_cnt = '0;
                    w_bit_cnt  = '0;
                    w_rx_sr    = '0;
                    w_crc      = '0;
                    w_crc_err  = 1'b0;
                    w_timeout  = 1'b0;
                    w_state    = RX_WAIT;
                end
            end
            TX_SHIFT: begin
                if (!enable_pts) begin
                    w_state = IDLE;
                end else if (r_bit_cnt == LP_TX_LEN) begin
                    w_tx_done = 1'b1;
                    w_state   = TX_DONE;
                end else begin
                    w_cmd_oe  = pad_state & pad_enable;
                    w_bit_cnt = r_bit_cnt + 8'd1;
                    if (r_bit_cnt == LP_TX_CRC) begin
                        w_cmd_out = r_crc[6];
                        w_tx_sr   = {r_crc, 1'b1, 40'd0};
                    end else begin
                        w_cmd_out = r_tx_sr[46];
                        w_tx_sr   = {r_tx_sr[46:0], 1'b0};
                        if (r_bit_cnt < LP_TX_CRC)
                            w_crc = crc7_step(r_crc, r_tx_sr[46]);
                    end
                end
            end
            TX_DONE: begin
                if (!enable_pts) begin
                    w_tx_done = 1'b0;
                    w_state   = IDLE;
                end
            end
            RX_WAIT: begin
                if (!enable_stp) begin
                    w_state = IDLE;
                end else if (!cmd_in) begin
                    w_rx_sr   = w_rx_shifted;
                    w_bit_cnt = 8'd1;
                    if (w_crc_en)
                        w_crc = crc7_step(r_crc, cmd_in);
                    w_state   = RX_SHIFT;
                end else begin
                    w_wait_cnt = r_wait_cnt + 8'd1;
                    if (r_wait_cnt + 8'd1 == LP_NCR) begin
                        w_timeout = 1'b1;
                        w_resp    = '0;
                        w_rx_done = 1'b1;
                        w_state   = RX_DONE;
                    end
                end
            end
            RX_SHIFT: begin
                if (!enable_stp) begin
                    w_state = IDLE;
                end else begin
                    w_rx_sr   = w_rx_shifted;
                    w_bit_cnt = r_bit_cnt + 8'd1;
                    if (w_crc_en)
                        w_crc = crc7_step(r_crc, cmd_in);
                    if (r_bit_cnt + 8'd1 == w_len) begin
                        w_resp    = w_rx_shifted;
                        w_crc_err = (w_rx_shifted[7:1] != r_crc) | ~cmd_in;
                        w_timeout = 1'b0;
                        w_rx_done = 1'b1;
                        w_state   = RX_DONE;
                    end
                end
            end
            RX_DONE: begin
                if (!enable_stp) begin
                    w_rx_done = 1'b0;
                    w_state   = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge sd_clock) begin
        if (reset || reset_wrapper) begin
            r_state    <= IDLE;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_crc      <= '0;
            r_long     <= 1'b0;
            r_cmd_out  <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_done  <= 1'b0;
            r_resp     <= '0;
            r_crc_err  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_tx_sr    <= w_tx_sr;
            r_rx_sr    <= w_rx_sr;
            r_bit_cnt  <= w_bit_cnt;
            r_wait_cnt <= w_wait_cnt;
            r_crc      <= w_crc;
            r_long     <= w_long;
            r_cmd_out  <= w_cmd_out;
            r_cmd_oe   <= w_cmd_oe;
            r_tx_done  <= w_tx_done;
            r_rx_done  <= w_rx_done;
            r_resp     <= w_resp;
            r_crc_err  <= w_crc_err;
            r_timeout  <= w_timeout;
        end
    end

    assign cmd_out               = r_cmd_out;
    assign cmd_oe                = r_cmd_oe;
    assign transmission_complete = r_tx_done;
    assign reception_complete    = r_rx_done;
    assign pad_response          = r_resp;
    assign crc_error             = r_crc_err;
    assign timeout               = r_timeout;

endmodule

// File: tb/tb_cmd_pad_serdes.sv
// Self-checking bench for cmd_pad_serdes: vector tables for known SD commands
// and responses, randomized frames against a polynomial-division CRC model.
module tb_cmd_pad_serdes;

    logic         sd_clock = 1'b0;
    logic         reset = 1'b1;
    logic         reset_wrapper = 1'b0;
    logic         enable_pts = 1'b0;
    logic         enable_stp = 1'b0;
    logic         pad_state = 1'b1;
    logic         pad_enable = 1'b1;
    logic         long_resp = 1'b0;
    logic [39:0]  cmd_to_send = '0;
    logic         cmd_in = 1'b1;
    logic         cmd_out;
    logic         cmd_oe;
    logic         transmission_complete;
    logic         reception_complete;
    logic [135:0] pad_response;
    logic         crc_error;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sd_clock = ~sd_clock;

    cmd_pad_serdes #(.NCR_MAX(64), .SHORT_LEN(48), .LONG_LEN(136)) dut (
        .sd_clock              (sd_clock),
        .reset                 (reset),
        .reset_wrapper         (reset_wrapper),
        .enable_pts            (enable_pts),
        .enable_stp            (enable_stp),
        .pad_state             (pad_state),
        .pad_enable            (pad_enable),
        .long_resp             (long_resp),
        .cmd_to_send           (cmd_to_send),
        .cmd_in                (cmd_in),
        .cmd_out               (cmd_out),
        .cmd_oe                (cmd_oe),
        .transmission_complete (transmission_complete),
        .reception_complete    (reception_complete),
        .pad_response          (pad_response),
        .crc_error             (crc_error),
        .timeout               (timeout)
    );

    typedef struct {
        logic [39:0] cmd;
        logic        ps;
        logic        pe;
        logic [47:0] frame;
        logic        oe;
    } tx_vec_t;

    typedef struct {
        logic [47:0] frame;
        logic        err;
    } rx_vec_t;

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, over bits msb..lsb of v.
    function automatic logic [6:0] ref_crc7(input logic [135:0] v, input int msb, input int lsb);
        logic [142:0] r;
        int n;
        n = msb - lsb + 1;
        r = '0;
        for (int i = 0; i < n; i++) r[i+7] = v[lsb+i];
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic ref_err(input logic [135:0] f, input logic lng);
        logic [6:0] c;
        c = lng ? ref_crc7(f, 127, 8) : ref_crc7(f, 47, 8);
        return (f[7:1] != c) || !f[0];
    endfunction

    task automatic do_tx(input logic [39:0] cmd, input logic [47:0] exp_frame,
                         input logic exp_oe, input string tag);
        logic [47:0] got;
        int oe_bad, early;
        got = '0; oe_bad = 0; early = 0;
        cmd_to_send = cmd;
        enable_pts  = 1'b1;
        tick();
        cmd_to_send = ~cmd;
        for (int i = 0; i < 48; i++) begin
            got[47-i] = cmd_out;
            if (cmd_oe !== exp_oe) oe_bad++;
            if (transmission_complete !== 1'b0) early++;
            tick();
        end
        check({tag, "_frame"}, 136'(got), 136'(exp_frame));
        check({tag, "_oe_bad_cycles"}, 136'(oe_bad), 136'd0);
        check({tag, "_early_done"}, 136'(early), 136'd0);
        check({tag, "_done"}, 136'(transmission_complete), 136'd1);
        check({tag, "_idle_pad"}, 136'({cmd_out, cmd_oe}), 136'b10);
        enable_pts = 1'b0;
        tick();
        check({tag, "_done_drop"}, 136'(transmission_complete), 136'd0);
    endtask

    task automatic do_rx(input logic lng, input logic [135:0] frame, input int idle,
                         input logic [135:0] exp_resp, input logic exp_err, input string tag);
        int len, early;
        early = 0;
        len = lng ? 136 : 48;
        long_resp  = lng;
        enable_stp = 1'b1;
        cmd_in     = 1'b1;
        tick();
        long_resp = ~lng;
        repeat (idle) tick();
        for (int i = len - 1; i >= 0; i--) begin
            cmd_in = frame[i];
            tick();
            if (i > 0 && reception_complete !== 1'b0) early++;
        end
        cmd_in = 1'b1;
        check({tag, "_early_done"}, 136'(early), 136'd0);
        check({tag, "_done"}, 136'(reception_complete), 136'd1);
        check({tag, "_resp"}, pad_response, exp_resp);
        check({tag, "_crc_err"}, 136'(crc_error), 136'(exp_err));
        check({tag, "_timeout"}, 136'(timeout), 136'd0);
        enable_stp = 1'b0;
        tick();
        check({tag, "_done_drop"}, 136'(reception_complete), 136'd0);
        long_resp = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_vec_t      tx_tab[5];
        rx_vec_t      rx_tab[3];
        logic [135:0] f, f2, last_resp;
        logic         good;
        int           idx, early;

        tx_tab[0] = '{40'h4000000000, 1'b1, 1'b1, 48'h400000000095, 1'b1};
        tx_tab[1] = '{40'h48000001AA, 1'b1, 1'b1, 48'h48000001AA87, 1'b1};
        tx_tab[2] = '{40'h7700000000, 1'b1, 1'b1, 48'h770000000065, 1'b1};
        tx_tab[3] = '{40'h6940000000, 1'b1, 1'b1, 48'h694000000077, 1'b1};
        tx_tab[4] = '{40'h4000000000, 1'b1, 1'b0, 48'h400000000095, 1'b0};
        rx_tab[0] = '{48'h110000090067, 1'b0};
        rx_tab[1] = '{48'h110000090065, 1'b1};
        rx_tab[2] = '{48'h110000090066, 1'b1};

        repeat (3) tick();
        check("reset_pad", 136'({cmd_out, cmd_oe}), 136'b10);
        check("reset_flags", 136'({transmission_complete, reception_complete, crc_error, timeout}), 136'd0);
        check("reset_resp", pad_response, 136'd0);
        reset = 1'b0;
        tick();

        foreach (tx_tab[i]) begin
            pad_state  = tx_tab[i].ps;
            pad_enable = tx_tab[i].pe;
            do_tx(tx_tab[i].cmd, tx_tab[i].frame, tx_tab[i].oe, $sformatf("tx%0d", i));
        end
        pad_state = 1'b1; pad_enable = 1'b1;

        for (int i = 0; i < 4; i++) begin
            f = {$urandom, $urandom, $urandom};
            do_tx(f[39:0], {f[39:0], ref_crc7(136'(f[39:0]), 39, 0), 1'b1}, 1'b1, $sformatf("txr%0d", i));
        end

        foreach (rx_tab[i])
            do_rx(1'b0, 136'(rx_tab[i].frame), 10, 136'(rx_tab[i].frame), rx_tab[i].err,
                  $sformatf("rx%0d", i));

        for (int i = 0; i < 10; i++) begin
            f = '0;
            f[47:8] = {$urandom, 8'($urandom_range(0, 255))};
            f[47] = 1'b0;
            good = (i % 2) == 0;
            if (good) f[7:0] = {ref_crc7(f, 47, 8), 1'b1};
            else      f[7:0] = 8'($urandom_range(0, 255));
            do_rx(1'b0, f, $urandom_range(0, 40), f, ref_err(f, 1'b0), $sformatf("rxr%0d", i));
        end

        for (int i = 0; i < 3; i++) begin
            f = {$urandom, $urandom, $urandom, $urandom, $urandom};
            f[135] = 1'b0;
            f[7:0] = {ref_crc7(f, 127, 8), 1'b1};
            do_rx(1'b1, f, $urandom_range(0, 20), f, 1'b0, $sformatf("r2_%0d", i));
            f2 = f;
            idx = $urandom_range(8, 127);
            f2[idx] = ~f2[idx];
            do_rx(1'b1, f2, 5, f2, 1'b1, $sformatf("r2bad_%0d", i));
            last_resp = f2;
        end

        // RX abort mid-frame: no completion, previous response kept
        enable_stp = 1'b1;
        tick();
        f = 136'h0123456789AB;
        for (int i = 47; i > 27; i--) begin
            cmd_in = f[i];
            tick();
        end
        enable_stp = 1'b0;
        cmd_in = 1'b1;
        tick();
        check("rx_abort_done", 136'(reception_complete), 136'd0);
        check("rx_abort_resp", pad_response, last_resp);
        repeat (3) tick();
        check("rx_abort_idle", 136'(reception_complete), 136'd0);

        // Timeout after exactly 64 wait cycles
        enable_stp = 1'b1;
        tick();
        early = 0;
        for (int c = 1; c <= 64; c++) begin
            tick();
            if (c < 64 && reception_complete !== 1'b0) early++;
        end
        check("to_early", 136'(early), 136'd0);
        check("to_done", 136'(reception_complete), 136'd1);
        check("to_flag", 136'(timeout), 136'd1);
        check("to_resp", pad_response, 136'd0);
        check("to_crc_err", 136'(crc_error), 136'd0);
        enable_stp = 1'b0;
        tick();
        check("to_drop", 136'(reception_complete), 136'd0);

        // reset_wrapper during TX bit 20
        cmd_to_send = 40'h48000001AA;
        enable_pts  = 1'b1;
        tick();
        repeat (20) tick();
        check("rw_pre_oe", 136'(cmd_oe), 136'd1);
        reset_wrapper = 1'b1;
        tick();
        check("rw_pad", 136'({cmd_out, cmd_oe}), 136'b10);
        check("rw_done", 136'(transmission_complete), 136'd0);
        reset_wrapper = 1'b0;
        enable_pts = 1'b0;
        tick();
        tick();
        check("rw_idle_pad", 136'({cmd_out, cmd_oe}), 136'b10);

        // TX abort by dropping enable_pts
        cmd_to_send = 40'h7700000000;
        enable_pts = 1'b1;
        tick();
        repeat (10) tick();
        enable_pts = 1'b0;
        tick();
        check("tx_abort_pad", 136'({cmd_out, cmd_oe}), 136'b10);
        check("tx_abort_done", 136'(transmission_complete), 136'd0);
        tick();

        // Both enables high: TX runs, RX ignored even with cmd_in low
        enable_stp = 1'b1;
        cmd_in = 1'b0;
        do_tx(40'h4000000000, 48'h400000000095, 1'b1, "both");
        check("both_no_rx", 136'(reception_complete), 136'd0);
        check("both_resp_kept", pad_response, 136'd0);
        enable_stp = 1'b0;
        cmd_in = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
